// File: rtl/accum_pkg.sv
// accum_bank shared types and helpers.
// Op codes, controller states, extended-width helper.
package accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  function automatic int ext_w(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/accum_alu.sv
// accum_bank write-stage arithmetic.
// Computes next accumulator value and overflow.
module accum_alu
  import accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] data,
  input  op_e               op,
  input  logic              sat,
  output logic [ACC_W-1:0]  nxt,
  output logic              ovf_set
);

  localparam int EW = ext_w(ACC_W);

  logic [EW-1:0] a_x;
  logic [EW-1:0] d_x;
  logic [EW-1:0] sum;
  logic [EW-1:0] dif;

  assign a_x = {1'b0, acc};
  assign d_x = {{(EW-DATA_W){1'b0}}, data};
  assign sum = a_x + d_x;
  // top bit of the difference is the borrow, i.e. data > acc
  assign dif = a_x - d_x;

  always_comb begin
    nxt     = acc;
    ovf_set = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        ovf_set = sum[ACC_W];
        nxt     = (sum[ACC_W] && sat) ?
                  {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end
      (op == OP_SUB): begin
        ovf_set = dif[ACC_W];
        nxt     = (dif[ACC_W] && sat) ?
                  '0 : dif[ACC_W-1:0];
      end
      (op == OP_LOAD): begin
        nxt = d_x[ACC_W-1:0];
      end
      (op == OP_CLR): begin
        nxt = '0;
      end
      default: begin
        nxt     = acc;
        ovf_set = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/accum_bank.sv
// Multi-channel accumulator bank.
// S1 request register, S2 array write, clear sweep.
module accum_bank
  import accum_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [1:0]          in_op,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sat,
  input  logic                clear_all,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [ACC_W-1:0]    rd_data,
  output logic [CHANNELS-1:0] ovf,
  output logic                busy
);

  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;

  logic              s1_vld;
  logic [CH_W-1:0]   s1_ch;
  op_e               s1_op;
  logic [DATA_W-1:0] s1_data;
  logic              s1_sat;

  state_e          state;
  logic [CH_W-1:0] idx;

  logic             take;
  logic             last;
  logic [ACC_W-1:0] alu_nxt;
  logic             alu_ovf;

  assign in_ready = (state == ST_IDLE) & ~clear_all;
  assign take     = in_valid & in_ready;
  assign busy     = (state == ST_SWEEP);
  assign last     = (idx == CH_W'(CHANNELS-1));
  assign ovf      = ovf_q;

  accum_alu #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_alu (
    .acc     (acc_q[s1_ch]),
    .data    (s1_data),
    .op      (s1_op),
    .sat     (s1_sat),
    .nxt     (alu_nxt),
    .ovf_set (alu_ovf)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_op   <= OP_ADD;
      s1_data <= '0;
      s1_sat  <= 1'b0;
    end else begin
      s1_vld <= take;
      if (take) begin
        s1_ch   <= in_ch;
        s1_op   <= op_e'(in_op);
        s1_data <= in_data;
        s1_sat  <= in_sat;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (clear_all) begin
            state <= ST_SWEEP;
            idx   <= '0;
          end
        end
        ST_SWEEP: begin
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= ST_IDLE;
        end
      endcase
    end
  end

  // S1 never holds a beat while sweeping, so the two writers never collide
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      ovf_q <= '0;
    end else if (busy) begin
      acc_q[idx] <= '0;
      ovf_q[idx] <= 1'b0;
    end else if (s1_vld) begin
      acc_q[s1_ch] <= alu_nxt;
      if (s1_op == OP_CLR) ovf_q[s1_ch] <= 1'b0;
      else if (alu_ovf)    ovf_q[s1_ch] <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) rd_data <= '0;
    else         rd_data <= acc_q[rd_ch];
  end

endmodule
